// File: rtl/multi_debounce_pkg.sv
// Shared defaults and helpers for the multi_debounce glitch filter.
// Holds the default parameter values and the width function for each channel's stability counter.
package multi_debounce_pkg;

  localparam int   DEF_CHANNELS      = 4;
  localparam int   DEF_STABLE_CYCLES = 4;
  localparam logic DEF_RESET_VALUE   = 1'b0;
  localparam int   DEF_GLITCH_W      = 8;

  // Wide enough to hold every value from 0 to stable_cycles.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: a stability counter, the filtered level and the rise/fall pulse flops.
// The level changes only after STABLE_CYCLES consecutive enabled samples that differ from it.
module debounce_channel
  import multi_debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic RESET_VALUE   = DEF_RESET_VALUE
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic s,
  output logic level,
  output logic rise,
  output logic fall,
  output logic glitch
);

  localparam int            CW   = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          level_next;
  logic          rise_next;
  logic          fall_next;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    cnt_next   = cnt;
    level_next = level;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    glitch     = 1'b0;
    if (en) begin
      if (s == level) begin
        cnt_next = '0;
        glitch   = (cnt != '0);
      end else if (cnt == LAST) begin
        level_next = s;
        cnt_next   = '0;
        rise_next  = s;
        fall_next  = ~s;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      cnt   <= '0;
      level <= RESET_VALUE;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      level <= level_next;
      rise  <= rise_next;
      fall  <= fall_next;
    end
  end

endmodule

// File: rtl/multi_debounce.sv
// Multi-channel debouncer with a shared saturating glitch counter.
// Define MULTI_DEBOUNCE_SYNC_EN to put a 2-flop synchroniser in front of every channel.
module multi_debounce
  import multi_debounce_pkg::*;
#(
  parameter int   CHANNELS      = DEF_CHANNELS,
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic RESET_VALUE   = DEF_RESET_VALUE,
  parameter int   GLITCH_W      = DEF_GLITCH_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic [CHANNELS-1:0] sig_in,
  input  logic                clr_glitch,
  output logic [CHANNELS-1:0] sig_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [GLITCH_W-1:0] glitch_count
);

  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] glitch_vec;
  logic                any_glitch;

`ifdef MULTI_DEBOUNCE_SYNC_EN
  logic [CHANNELS-1:0] sync_q1;
  logic [CHANNELS-1:0] sync_q2;

  // Free-running so the pipeline stays current while the filter is disabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q1 <= {CHANNELS{RESET_VALUE}};
      sync_q2 <= {CHANNELS{RESET_VALUE}};
    end else begin
      sync_q1 <= sig_in;
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = sig_in;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_VALUE  (RESET_VALUE)
    ) u_ch (
      .clock (clock),
      .reset (reset),
      .en    (en),
      .s     (s[i]),
      .level (sig_out[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .glitch(glitch_vec[i])
    );
  end

  // Several channels rejecting on one edge still count as a single event.
  assign any_glitch = |glitch_vec;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      glitch_count <= '0;
    end else if (clr_glitch) begin
      glitch_count <= '0;
    end else if (any_glitch && (glitch_count != '1)) begin
      glitch_count <= glitch_count + GLITCH_W'(1);
    end
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Directed self-checking bench for multi_debounce (CHANNELS=4, STABLE_CYCLES=4, GLITCH_W=8).
// Latencies stretch by two edges when MULTI_DEBOUNCE_SYNC_EN is defined.
module tb_multi_debounce;

`ifdef MULTI_DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clock;
  logic       reset;
  logic       en;
  logic [3:0] sig_in;
  logic       clr_glitch;
  logic [3:0] sig_out;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [7:0] glitch_count;

  int n_cmp;
  int n_err;

  multi_debounce #(
    .CHANNELS     (4),
    .STABLE_CYCLES(4),
    .RESET_VALUE  (1'b0),
    .GLITCH_W     (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .sig_in      (sig_in),
    .clr_glitch  (clr_glitch),
    .sig_out     (sig_out),
    .rise        (rise),
    .fall        (fall),
    .glitch_count(glitch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic [3:0] v);
    sig_in = v;
    tick();
  endtask

  task automatic check_outs(input string tag, input logic [3:0] lvl, input logic [3:0] r,
                            input logic [3:0] f);
    check({tag, ".sig_out"}, 32'(sig_out), 32'(lvl));
    check({tag, ".rise"}, 32'(rise), 32'(r));
    check({tag, ".fall"}, 32'(fall), 32'(f));
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b0;
    en         = 1'b1;
    sig_in     = 4'b0000;
    clr_glitch = 1'b0;

    // Reset, then 20 quiet cycles
    tick();
    tick();
    check_outs("in_reset", 4'b0000, 4'b0000, 4'b0000);
    check("in_reset.glitch", 32'(glitch_count), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(4'b0000);
      check_outs("idle", 4'b0000, 4'b0000, 4'b0000);
      check("idle.glitch", 32'(glitch_count), 32'd0);
    end

    // Channel 0 rise after 4 samples, one-cycle pulse
    for (int i = 0; i < 3 + LAT; i++) begin
      step(4'b0001);
      check_outs("ch0_pre_rise", 4'b0000, 4'b0000, 4'b0000);
    end
    step(4'b0001);
    check_outs("ch0_rise", 4'b0001, 4'b0001, 4'b0000);
    step(4'b0001);
    check_outs("ch0_rise_end", 4'b0001, 4'b0000, 4'b0000);

    // Channel 0 fall
    for (int i = 0; i < 3 + LAT; i++) begin
      step(4'b0000);
      check_outs("ch0_pre_fall", 4'b0001, 4'b0000, 4'b0000);
    end
    step(4'b0000);
    check_outs("ch0_fall", 4'b0000, 4'b0000, 4'b0001);
    step(4'b0000);
    check_outs("ch0_fall_end", 4'b0000, 4'b0000, 4'b0000);
    check("ch0_no_glitch", 32'(glitch_count), 32'd0);

    // Channel 1: 1,1,1,0 rejected, then 1,1,1,1 accepted on edge 8
    step(4'b0010);
    step(4'b0010);
    step(4'b0010);
    step(4'b0000);
    step(4'b0010);
    step(4'b0010);
    step(4'b0010);
    for (int i = 0; i < LAT; i++) step(4'b0010);
    check_outs("ch1_edge7", 4'b0000, 4'b0000, 4'b0000);
    check("ch1_glitch1", 32'(glitch_count), 32'd1);
    step(4'b0010);
    check_outs("ch1_edge8", 4'b0010, 4'b0010, 4'b0000);
    check("ch1_glitch_hold", 32'(glitch_count), 32'd1);

    // Channels 2 and 3 reject on the same edge: one increment
    step(4'b1110);
    step(4'b0010);
    for (int i = 0; i < LAT; i++) step(4'b0010);
    check("dual_glitch", 32'(glitch_count), 32'd2);
    check_outs("dual_glitch", 4'b0010, 4'b0000, 4'b0000);

    // Drive the count to saturation
    for (int i = 0; i < 253; i++) begin
      step(4'b0110);
      step(4'b0010);
    end
    for (int i = 0; i < LAT; i++) step(4'b0010);
    check("glitch_255", 32'(glitch_count), 32'd255);
    step(4'b0110);
    step(4'b0010);
    for (int i = 0; i < LAT; i++) step(4'b0010);
    check("glitch_sat", 32'(glitch_count), 32'd255);

    // Clear on the same edge as a reject wins
    step(4'b0110);
    sig_in = 4'b0010;
    for (int i = 0; i < LAT; i++) tick();
    clr_glitch = 1'b1;
    tick();
    clr_glitch = 1'b0;
    check("clr_with_glitch", 32'(glitch_count), 32'd0);
    step(4'b0010);
    check("clr_stays", 32'(glitch_count), 32'd0);
    check_outs("clr_outs", 4'b0010, 4'b0000, 4'b0000);

    // Enable gap: 2 samples, 5 disabled cycles, 2 more samples
    sig_in = 4'b0011;
    for (int i = 0; i < LAT; i++) tick();
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_outs("en_low", 4'b0010, 4'b0000, 4'b0000);
    end
    en = 1'b1;
    tick();
    check_outs("en_re1", 4'b0010, 4'b0000, 4'b0000);
    tick();
    check_outs("en_re2", 4'b0011, 4'b0001, 4'b0000);
    check("en_no_glitch", 32'(glitch_count), 32'd0);

    // Reset after 3 of 4 samples on channel 2
    sig_in = 4'b0111;
    for (int i = 0; i < LAT + 3; i++) tick();
    check_outs("pre_reset", 4'b0011, 4'b0000, 4'b0000);
    reset = 1'b0;
    #1;
    check_outs("async_reset", 4'b0000, 4'b0000, 4'b0000);
    tick();
    tick();
    check_outs("held_reset", 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b1;
    for (int i = 0; i < 3 + LAT; i++) begin
      tick();
      check_outs("post_reset_count", 4'b0000, 4'b0000, 4'b0000);
    end
    tick();
    check_outs("post_reset_rise", 4'b0111, 4'b0111, 4'b0000);
    tick();
    check_outs("post_reset_end", 4'b0111, 4'b0000, 4'b0000);
    check("post_reset_glitch", 32'(glitch_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_debounce.md
# multi_debounce

Parametrised multi-channel glitch filter / debouncer for slow, noisy single-bit inputs such as buttons, switches and external status lines. Each channel's filtered output changes only after its input has held the opposite level for a programmable number of consecutive enabled clock cycles. Each channel also produces single-cycle rise and fall pulses, and a shared saturating counter records rejected glitches. It sits between raw pad inputs and control logic, replacing the fixed single-channel filter.

## Interface
- CHANNELS, 4, number of independent filtered channels (1..32)
- STABLE_CYCLES, 4, consecutive differing samples required to change an output (1..65535)
- RESET_VALUE, 1'b0, level loaded into every `sig_out` bit and synchroniser flop at reset
- GLITCH_W, 8, width of the glitch counter
- clock  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low; asserts immediately, releases synchronously to `clock` externally
- en  input  1  sample enable; when low, all channel state holds
- sig_in  input  CHANNELS  raw inputs, one bit per channel
- clr_glitch  input  1  synchronous clear of `glitch_count`
- sig_out  output  CHANNELS  filtered levels
- rise  output  CHANNELS  one-cycle pulse on the edge where `sig_out[i]` goes 0->1
- fall  output  CHANNELS  one-cycle pulse on the edge where `sig_out[i]` goes 1->0
- glitch_count  output  GLITCH_W  saturating count of cycles with at least one rejected glitch

## Operation
- Per-channel state: `sig_out[i]` and counter `cnt[i]`, width clog2(STABLE_CYCLES+1). `s[i]` is the sampled input: `sig_in[i]` directly, or the synchroniser output (see Configuration).
- On a clock edge with `en` high:
  - If `s[i] == sig_out[i]`: `cnt[i]` <= 0. If `cnt[i]` was nonzero, this is a glitch reject.
  - Otherwise, if `cnt[i]+1 == STABLE_CYCLES`: `sig_out[i]` <= `s[i]`, `cnt[i]` <= 0, and `rise[i]` or `fall[i]` <= 1 according to the new level.
  - Otherwise: `cnt[i]` <= `cnt[i]+1`.
- `en` low: `cnt`, `sig_out` and `glitch_count` hold (except clear); `rise`/`fall` <= 0; no glitch detection.
- `glitch_count` increments by exactly 1 per edge on which any channel has a glitch reject, regardless of how many channels reject. It saturates at 2^GLITCH_W-1.
- `clr_glitch` has priority over increment: the count becomes 0 on that edge.
- STABLE_CYCLES=1: output follows `s` with one-cycle latency; glitch rejects are impossible.
- Channels are fully independent. Simultaneous transitions on several channels each complete on their own count.

## Timing
- Reset values: `sig_out` = {CHANNELS{RESET_VALUE}}, `cnt` = 0, `rise` = `fall` = 0, `glitch_count` = 0, synchroniser flops = RESET_VALUE.
- Latency without the synchroniser: `sig_out[i]` changes on the Nth consecutive enabled edge that samples the opposite level (N = STABLE_CYCLES). `rise`/`fall` assert on that same edge and drop on the next edge.
- The synchroniser adds exactly 2 cycles of latency.
- Any single sample equal to `sig_out[i]` restarts the count from 0.
- Cycles with `en` low neither break nor extend an ongoing count.
- Reset asserted mid-count: all state returns to reset values immediately. No pulse is emitted.
- `glitch_count` and a `sig_out` change can update on the same edge when different channels are involved.

## Configuration
- Macro: `MULTI_DEBOUNCE_SYNC_EN`.
- When defined: each `sig_in[i]` passes through a 2-flop synchroniser (always clocked, independent of `en`) before the filter. Total latency is N+2.
- When undefined: `sig_in` feeds the filter directly. The bench must drive it synchronously.

## Structure
- Shared package `multi_debounce_pkg` holds the default parameter constants and the clog2 width function used for `cnt`.
- Sub-module `debounce_channel` holds the per-channel counter, level register and pulse flops. It is instantiated CHANNELS times via generate.
- The top level holds the optional synchroniser, the OR-reduction of glitch rejects, and the glitch counter.

## Test plan
- Reset release with CHANNELS=4, STABLE_CYCLES=4: hold `sig_in` = 4'b0000 -> `sig_out` = 0, no pulses, `glitch_count` = 0 for 20 cycles.
- Channel 0 driven high for 4 edges -> `sig_out[0]` = 1 on the 4th edge and `rise[0]` high for exactly one cycle. Then low for 4 edges -> `fall[0]` pulse and `sig_out[0]` = 0.
- Channel 1 pattern 1,1,1,0,1,1,1,1 -> first burst rejected and `glitch_count` = 1. `sig_out[1]` rises on the 4th edge of the second run (edge 8).
- Channels 2 and 3 glitch on the same edge -> `glitch_count` increases by 1 only. With the count at 255 and another glitch, it stays 255. Asserting `clr_glitch` together with a glitch -> 0.
- `en` low for 5 cycles after 2 high samples on channel 0, then 2 more high samples with `en` high -> output changes on the 2nd re-enabled edge. No pulse while disabled.
- Reset asserted after 3 of 4 samples -> `sig_out` returns to RESET_VALUE immediately. After release, 4 fresh samples are needed. With `MULTI_DEBOUNCE_SYNC_EN` defined, every latency above is 2 cycles longer.
